// File: rtl/zz_block_scheduler.sv
// -----------------------------------------------------------------------------
// zz_block_scheduler
//
// Frame-level sequencer for the quantiser/ZigZag stage. For each 8x8 block it
// waits until the DCT buffer holds a block and the entropy encoder is ready,
// then drives the ZigZag start level for 64 cycles while stepping a 6-bit
// coefficient index, releases the DCT buffer, and lets the ZigZag pipeline
// drain before moving to the next block. Blocks are counted per MCU and MCUs
// per frame; component / quant-table selects follow the block position.
//
// Build option:
//   SUBSAMPLE_422_EN  defined   -> 4:2:2, 4 blocks per MCU (Y,Y,Cb,Cr)
//                     undefined -> 4:2:0, 6 blocks per MCU (Y,Y,Y,Y,Cb,Cr)
//
// Ports:
//   sys_clk      in   clock, rising edge
//   sys_rst      in   synchronous reset, active-high
//   frame_start  in   1-cycle pulse, starts a frame (honoured in IDLE only)
//   dct_blk_rdy  in   DCT buffer holds a complete block
//   enc_ready    in   downstream encoder can take a new block
//   zz_start     out  ZigZag start level, high for the 64 feed cycles
//   coef_idx     out  coefficient index fed this cycle (0..63)
//   dct_blk_ack  out  1-cycle pulse on the last feed cycle
//   comp_id      out  0=Y 1=Cb 2=Cr
//   qtab_sel     out  0=luma table, 1=chroma table
//   zz_valid     out  zz_start delayed ZZ_LAT cycles
//   zz_last      out  coefficient 63 marker delayed ZZ_LAT cycles
//   blk_in_mcu   out  block index inside the current MCU
//   mcu_x/mcu_y  out  current MCU column / row
//   busy         out  high whenever not IDLE
//   frame_done   out  1-cycle pulse after the last block of a frame drains
// -----------------------------------------------------------------------------
module zz_block_scheduler #(
    parameter int MCU_W  = 20,
    parameter int MCU_H  = 15,
    parameter int CNT_W  = 8,
    parameter int ZZ_LAT = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             frame_start,
    input  logic             dct_blk_rdy,
    input  logic             enc_ready,
    output logic             zz_start,
    output logic [5:0]       coef_idx,
    output logic             dct_blk_ack,
    output logic [1:0]       comp_id,
    output logic             qtab_sel,
    output logic             zz_valid,
    output logic             zz_last,
    output logic [2:0]       blk_in_mcu,
    output logic [CNT_W-1:0] mcu_x,
    output logic [CNT_W-1:0] mcu_y,
    output logic             busy,
    output logic             frame_done
);

`ifdef SUBSAMPLE_422_EN
    localparam int YB  = 2;
    localparam int BPM = 4;
`else
    localparam int YB  = 4;
    localparam int BPM = 6;
`endif

    localparam int DW = (ZZ_LAT > 1) ? $clog2(ZZ_LAT) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_FEED  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [5:0]       coef_q, coef_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [2:0]       blk_q, blk_d;
    logic [CNT_W-1:0] mcux_q, mcux_d;
    logic [CNT_W-1:0] mcuy_q, mcuy_d;
    logic             done_q, done_d;
    logic [ZZ_LAT-1:0] valid_sr_q, valid_sr_d;
    logic [ZZ_LAT-1:0] last_sr_q, last_sr_d;

    logic feed;
    logic last_coef;
    logic frame_end;

    assign feed      = (state_q == ST_FEED);
    assign last_coef = feed && (coef_q == 6'd63);
    assign frame_end = (blk_q == 3'(BPM - 1)) &&
                       (mcux_q == CNT_W'(MCU_W - 1)) &&
                       (mcuy_q == CNT_W'(MCU_H - 1));

    always_comb begin
        state_d = state_q;
        coef_d  = coef_q;
        drain_d = drain_q;
        blk_d   = blk_q;
        mcux_d  = mcux_q;
        mcuy_d  = mcuy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The frame_done cycle is still part of the finished frame,
                // so a start request landing on it is dropped.
                if (frame_start && !done_q) begin
                    state_d = ST_WAIT;
                    blk_d   = '0;
                    mcux_d  = '0;
                    mcuy_d  = '0;
                end
            end
            ST_WAIT: begin
                if (dct_blk_rdy && enc_ready) begin
                    state_d = ST_FEED;
                    coef_d  = 6'd0;
                end
            end
            ST_FEED: begin
                // 63 + 1 wraps to 0, leaving the index clean for the next block.
                coef_d = coef_q + 6'd1;
                if (coef_q == 6'd63) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
            default: begin
                drain_d = drain_q + DW'(1);
                if (drain_q == DW'(ZZ_LAT - 1)) begin
                    if (frame_end) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        if (blk_q == 3'(BPM - 1)) begin
                            blk_d = '0;
                            if (mcux_q == CNT_W'(MCU_W - 1)) begin
                                mcux_d = '0;
                                mcuy_d = mcuy_q + CNT_W'(1);
                            end else begin
                                mcux_d = mcux_q + CNT_W'(1);
                            end
                        end else begin
                            blk_d = blk_q + 3'd1;
                        end
                    end
                end
            end
        endcase
    end

    // Output-alignment delay lines: stage 0 takes the live feed flags,
    // each later stage copies its predecessor.
    genvar gi;
    generate
        for (gi = 0; gi < ZZ_LAT; gi++) begin : g_dly
            if (gi == 0) begin : g_head
                assign valid_sr_d[gi] = feed;
                assign last_sr_d[gi]  = last_coef;
            end else begin : g_tail
                assign valid_sr_d[gi] = valid_sr_q[gi-1];
                assign last_sr_d[gi]  = last_sr_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            coef_q     <= '0;
            drain_q    <= '0;
            blk_q      <= '0;
            mcux_q     <= '0;
            mcuy_q     <= '0;
            done_q     <= 1'b0;
            valid_sr_q <= '0;
            last_sr_q  <= '0;
        end else begin
            state_q    <= state_d;
            coef_q     <= coef_d;
            drain_q    <= drain_d;
            blk_q      <= blk_d;
            mcux_q     <= mcux_d;
            mcuy_q     <= mcuy_d;
            done_q     <= done_d;
            valid_sr_q <= valid_sr_d;
            last_sr_q  <= last_sr_d;
        end
    end

    assign zz_start    = feed;
    assign coef_idx    = coef_q;
    assign dct_blk_ack = last_coef;
    assign comp_id     = (blk_q < 3'(YB))  ? 2'd0 :
                         (blk_q == 3'(YB)) ? 2'd1 : 2'd2;
    assign qtab_sel    = (comp_id != 2'd0);
    assign zz_valid    = valid_sr_q[ZZ_LAT-1];
    assign zz_last     = last_sr_q[ZZ_LAT-1];
    assign blk_in_mcu  = blk_q;
    assign mcu_x       = mcux_q;
    assign mcu_y       = mcuy_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = done_q;

endmodule

// File: tb/tb_zz_block_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for zz_block_scheduler (MCU_W=2, MCU_H=1, ZZ_LAT=2).
// Stimulus pushes the expected block sequence of each frame into a queue;
// a negedge monitor pops one entry per block and checks block position,
// component selects, coefficient stepping, ack and output-delay alignment.
// -----------------------------------------------------------------------------
module tb_zz_block_scheduler;

    localparam int MCU_W  = 2;
    localparam int MCU_H  = 1;
    localparam int CNT_W  = 8;
    localparam int ZZ_LAT = 2;
`ifdef SUBSAMPLE_422_EN
    localparam int YB  = 2;
    localparam int BPM = 4;
`else
    localparam int YB  = 4;
    localparam int BPM = 6;
`endif
    localparam int NBLK      = MCU_W * MCU_H * BPM;
    localparam int FRAME_CYC = NBLK * (1 + 64 + ZZ_LAT) + 1;

    logic             sys_clk = 1'b0;
    logic             sys_rst;
    logic             frame_start;
    logic             dct_blk_rdy;
    logic             enc_ready;
    logic             zz_start;
    logic [5:0]       coef_idx;
    logic             dct_blk_ack;
    logic [1:0]       comp_id;
    logic             qtab_sel;
    logic             zz_valid;
    logic             zz_last;
    logic [2:0]       blk_in_mcu;
    logic [CNT_W-1:0] mcu_x;
    logic [CNT_W-1:0] mcu_y;
    logic             busy;
    logic             frame_done;

    zz_block_scheduler #(
        .MCU_W (MCU_W),
        .MCU_H (MCU_H),
        .CNT_W (CNT_W),
        .ZZ_LAT(ZZ_LAT)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .frame_start(frame_start),
        .dct_blk_rdy(dct_blk_rdy),
        .enc_ready  (enc_ready),
        .zz_start   (zz_start),
        .coef_idx   (coef_idx),
        .dct_blk_ack(dct_blk_ack),
        .comp_id    (comp_id),
        .qtab_sel   (qtab_sel),
        .zz_valid   (zz_valid),
        .zz_last    (zz_last),
        .blk_in_mcu (blk_in_mcu),
        .mcu_x      (mcu_x),
        .mcu_y      (mcu_y),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int blk;
        int x;
        int y;
        int comp;
    } blk_t;

    blk_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ack_cnt  = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame order: raster over MCUs, blocks within each MCU.
    task automatic push_frame();
        blk_t e;
        for (int y = 0; y < MCU_H; y++)
            for (int x = 0; x < MCU_W; x++)
                for (int b = 0; b < BPM; b++) begin
                    e.blk  = b;
                    e.x    = x;
                    e.y    = y;
                    e.comp = (b < YB) ? 0 : (b - YB + 1);
                    exp_q.push_back(e);
                end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    int              exp_idx = 0;
    logic [ZZ_LAT-1:0] vh = '0;
    logic [ZZ_LAT-1:0] lh = '0;

    always @(negedge sys_clk) begin
        blk_t e;
        if (sys_rst) begin
            exp_idx = 0;
            vh      = '0;
            lh      = '0;
        end else begin
            check("zz_valid_align", zz_valid, vh[ZZ_LAT-1]);
            check("zz_last_align", zz_last, lh[ZZ_LAT-1]);
            check("dct_blk_ack", dct_blk_ack, (zz_start && exp_idx == 63));
            if (dct_blk_ack) ack_cnt++;
            if (frame_done) done_cnt++;
            if (zz_start) begin
                check("coef_idx", coef_idx, exp_idx);
                if (exp_idx == 0 || exp_idx == 63) begin
                    if (exp_q.size() == 0) begin
                        check("blk_unexpected", 1, 0);
                    end else begin
                        e = exp_q[0];
                        check("blk_in_mcu", blk_in_mcu, e.blk);
                        check("mcu_x", mcu_x, e.x);
                        check("mcu_y", mcu_y, e.y);
                        check("comp_id", comp_id, e.comp);
                        check("qtab_sel", qtab_sel, (e.comp != 0));
                        if (exp_idx == 63) void'(exp_q.pop_front());
                    end
                end
            end
            for (int i = ZZ_LAT - 1; i > 0; i--) begin
                vh[i] = vh[i-1];
                lh[i] = lh[i-1];
            end
            vh[0]   = zz_start;
            lh[0]   = zz_start && (exp_idx == 63);
            exp_idx = zz_start ? ((exp_idx + 1) % 64) : 0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int k;
        int a0;
        logic seen;

        sys_rst     = 1'b1;
        frame_start = 1'b0;
        dct_blk_rdy = 1'b0;
        enc_ready   = 1'b0;
        repeat (3) tick();
        sys_rst = 1'b0;

        check("rst_busy", busy, 0);
        check("rst_zz_start", zz_start, 0);
        check("rst_coef_idx", coef_idx, 0);
        check("rst_blk", blk_in_mcu, 0);
        check("rst_mcu_x", mcu_x, 0);
        check("rst_frame_done", frame_done, 0);
        $display("reset: busy=%0d zz_start=%0d coef_idx=%0d", busy, zz_start, coef_idx);

        // Full frame with inputs held high, plus a stray mid-frame start.
        dct_blk_rdy = 1'b1;
        enc_ready   = 1'b1;
        push_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        cyc = 1;
        while (!frame_done && cyc < 3000) begin
            frame_start = (cyc == 300);
            tick();
            cyc++;
        end
        frame_start = 1'b0;
        check("t1_frame_done_cycle", cyc, FRAME_CYC);
        $display("frame1: frame_done at cycle %0d", cyc);
        // Start request on the frame_done cycle must be dropped.
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t1_busy_after_done", busy, 0);
        check("t1_single_done", frame_done, 0);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_ack_cnt", ack_cnt, NBLK);
        check("t1_queue_empty", exp_q.size(), 0);
        tick();

        // Encoder not ready holds off the feed.
        push_frame();
        dct_blk_rdy = 1'b1;
        enc_ready   = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (zz_start) seen = 1'b1;
        end
        check("t2_hold_off", seen, 0);
        enc_ready = 1'b1;
        tick();
        check("t2_start", zz_start, 1);
        check("t2_coef0", coef_idx, 0);
        $display("stall: zz_start=%0d after enc_ready", zz_start);

        // Inputs dropped mid-feed: block still completes with one ack.
        k = 0;
        while (coef_idx != 6'd10 && k < 100) begin
            tick();
            k++;
        end
        check("t3_reach_coef10", (k < 100), 1);
        dct_blk_rdy = 1'b0;
        enc_ready   = 1'b0;
        a0 = ack_cnt;
        repeat (60) tick();
        check("t3_one_ack", ack_cnt - a0, 1);
        check("t3_feed_done", zz_start, 0);
        check("t3_still_busy", busy, 1);
        $display("drop: acks=%0d", ack_cnt - a0);

        // Reset in the middle of the second block's feed.
        dct_blk_rdy = 1'b1;
        enc_ready   = 1'b1;
        k = 0;
        while (!(zz_start && coef_idx == 6'd30) && k < 200) begin
            tick();
            k++;
        end
        check("t4_reach_coef30", (k < 200), 1);
        sys_rst = 1'b1;
        tick();
        check("t4_zz_start", zz_start, 0);
        check("t4_coef_idx", coef_idx, 0);
        check("t4_busy", busy, 0);
        check("t4_blk", blk_in_mcu, 0);
        check("t4_ack", dct_blk_ack, 0);
        check("t4_zz_valid", zz_valid, 0);
        check("t4_zz_last", zz_last, 0);
        $display("reset mid-feed: busy=%0d zz_start=%0d", busy, zz_start);
        exp_q.delete();
        sys_rst = 1'b0;
        tick();

        // Randomly throttled frame after the reset.
        push_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t5_busy", busy, 1);
        check("t5_blk0", blk_in_mcu, 0);
        check("t5_mcu_x0", mcu_x, 0);
        check("t5_mcu_y0", mcu_y, 0);
        k = 0;
        while (!frame_done && k < 8000) begin
            dct_blk_rdy = ($urandom_range(0, 3) != 0);
            enc_ready   = ($urandom_range(0, 3) != 0);
            frame_start = ($urandom_range(0, 15) == 0);
            tick();
            k++;
        end
        frame_start = 1'b0;
        check("t5_finished", (k < 8000), 1);
        tick();
        check("t5_done_cnt", done_cnt, 2);
        check("t5_queue_empty", exp_q.size(), 0);
        check("t5_idle", busy, 0);
        $display("random frame: %0d cycles, done_cnt=%0d", k, done_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
